// File: rtl/ds_pkg.sv
// Shared types and constants for the ds_slice register-slice family.
package ds_pkg;

  // Flow-control flavour of a slice.
  typedef enum logic [1:0] {
    FC_BI,
    FC_UNI,
    FC_NO
  } t_fc;

  // Occupancy of one two-entry skid stage.
  typedef enum logic [1:0] {
    EMPTY,
    ONE,
    FULL
  } t_skid_state;

  localparam int DS_MAX_STAGES = 16;

  // Width of a counter that holds 0..2*stages words.
  function automatic int ds_cnt_w(input int stages);
    return $clog2(2 * stages + 1);
  endfunction

endpackage

// File: rtl/ds_if.sv
// Valid/ready data stream bundle carrying one DTYPE word per transfer.
interface ds_if #(
  parameter type         DTYPE = logic [7:0],
  parameter ds_pkg::t_fc FC    = ds_pkg::FC_BI
);
  logic vld;
  logic rdy;
  DTYPE data;

  // FC documents the intended use of the bundle; no signal depends on it.
  localparam ds_pkg::t_fc unused_fc = FC;

  modport mst (output vld, output data, input rdy);
  modport slv (input vld, input data, output rdy);
endinterface

// File: rtl/ds_skid.sv
// One fully registered valid/ready stage: a two-entry skid buffer whose
// upstream ready comes from a flop, so no combinational path crosses it.
module ds_skid
  import ds_pkg::*;
#(
  parameter type DTYPE = logic [7:0]
) (
  input logic clk,
  input logic rst_n,
  ds_if.slv   s,
  ds_if.mst   m
);

  t_skid_state state_q, state_d;
  logic        rdy_q;
  DTYPE        main_q, skid_q;
  logic        acc, drn;
  logic        load_main, main_from_skid, load_skid;

  assign acc = s.vld & rdy_q;
  assign drn = (state_q != EMPTY) & m.rdy;

  // Next occupancy and which payload register captures this cycle.
  always_comb begin
    // NOTE: every output gets a default first so no path infers a latch.
    state_d        = state_q;
    load_main      = 1'b0;
    main_from_skid = 1'b0;
    load_skid      = 1'b0;
    unique case (state_q)
      EMPTY: if (acc) begin
        state_d   = ONE;
        load_main = 1'b1;
      end
      ONE: begin
        if (acc && drn) begin
          load_main = 1'b1;
        end else if (acc) begin
          state_d   = FULL;
          load_skid = 1'b1;
        end else if (drn) begin
          state_d = EMPTY;
        end
      end
      FULL: if (drn) begin
        state_d        = ONE;
        main_from_skid = 1'b1;
      end
      default: state_d = EMPTY;
    endcase
  end

  // Occupancy and registered upstream ready; ready rises on the first edge out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: non-blocking assignments keep all flops updating from pre-edge values.
    if (!rst_n) begin
      state_q <= EMPTY;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rdy_q   <= (state_d != FULL);
    end
  end

  // Payload registers move only on accept or skid drain.
  always_ff @(posedge clk) begin
    // NOTE: payload registers carry no reset; the state flops qualify them.
    if (load_main)           main_q <= s.data;
    else if (main_from_skid) main_q <= skid_q;
    if (load_skid)           skid_q <= s.data;
  end

  assign s.rdy  = rdy_q;
  assign m.vld  = (state_q != EMPTY);
  assign m.data = main_q;

endmodule

// File: rtl/ds_slice.sv
// Configurable pipeline slice: STAGES skid buffers (FC_BI), a valid/data
// delay line (FC_UNI) or a bare data delay line (FC_NO), plus an occupancy count.
module ds_slice
  import ds_pkg::*;
#(
  parameter type DTYPE  = logic [7:0],
  parameter t_fc FC     = FC_BI,
  parameter int  STAGES = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  ds_if.slv                             s,
  ds_if.mst                             m,
  output logic [ds_cnt_w(STAGES)-1:0]   cnt
);

  localparam int CW = ds_cnt_w(STAGES);

  logic inc, dec;

  if (STAGES < 1 || STAGES > DS_MAX_STAGES) begin : g_bad_stages
    $error("ds_slice: STAGES=%0d outside 1..%0d", STAGES, DS_MAX_STAGES);
  end

  case (FC)
    FC_BI: begin : g_bi
      ds_if #(.DTYPE(DTYPE), .FC(FC)) lnk [STAGES+1] ();

      assign lnk[0].vld      = s.vld;
      assign lnk[0].data     = s.data;
      assign s.rdy           = lnk[0].rdy;
      assign m.vld           = lnk[STAGES].vld;
      assign m.data          = lnk[STAGES].data;
      assign lnk[STAGES].rdy = m.rdy;

      for (genvar i = 0; i < STAGES; i++) begin : g_st
        ds_skid #(.DTYPE(DTYPE)) u_skid (
          .clk   (clk),
          .rst_n (rst_n),
          .s     (lnk[i]),
          .m     (lnk[i+1])
        );
      end

      assign inc = s.vld & s.rdy;
      assign dec = m.vld & m.rdy;
    end

    FC_UNI: begin : g_uni
      logic [STAGES-1:0] vld_q;
      DTYPE              data_q [STAGES];
      logic              unused_rdy;

      // Valid shift register; downstream ready has no influence.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          vld_q <= '0;
        end else begin
          for (int i = STAGES - 1; i > 0; i--) vld_q[i] <= vld_q[i-1];
          vld_q[0] <= s.vld;
        end
      end

      // Data follows its valid bit; idle slots keep their old contents.
      always_ff @(posedge clk) begin
        if (s.vld) data_q[0] <= s.data;
        for (int i = 1; i < STAGES; i++) begin
          if (vld_q[i-1]) data_q[i] <= data_q[i-1];
        end
      end

      assign s.rdy      = 1'b1;
      assign m.vld      = vld_q[STAGES-1];
      assign m.data     = data_q[STAGES-1];
      assign unused_rdy = m.rdy;
      assign inc        = s.vld;
      assign dec        = vld_q[STAGES-1];
    end

    FC_NO: begin : g_no
      DTYPE data_q [STAGES];
      logic unused_vld, unused_rdy;

      // Plain data delay line, loaded every cycle.
      always_ff @(posedge clk) begin
        data_q[0] <= s.data;
        for (int i = 1; i < STAGES; i++) data_q[i] <= data_q[i-1];
      end

      assign s.rdy      = 1'b1;
      assign m.vld      = 1'b1;
      assign m.data     = data_q[STAGES-1];
      assign unused_vld = s.vld;
      assign unused_rdy = m.rdy;
      // Counts up once per cycle until the line is primed, then holds.
      assign inc        = (cnt != CW'(STAGES));
      assign dec        = 1'b0;
    end

    default: begin : g_bad_fc
      $error("ds_slice: unsupported flow-control mode");
      assign inc = 1'b0;
      assign dec = 1'b0;
    end
  endcase

  // Occupancy: words accepted minus words delivered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt <= '0;
    else        cnt <= cnt + CW'(inc) - CW'(dec);
  end

endmodule

// File: doc/ds_slice.md
DS_SLICE -- requirements
Module: ds_slice

Interface
REQ-001 SHALL have parameter DTYPE, default logic [7:0], payload type carried end to end.
REQ-002 SHALL have parameter FC, default FC_BI, flow-control mode of type t_fc (FC_BI / FC_UNI / FC_NO).
REQ-003 SHALL have parameter STAGES, default 2, number of register stages; legal range 1..16, other values fail elaboration.
REQ-004 SHALL have port clk, input, 1 bit, single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit; reset is asynchronous and active-low.
REQ-006 SHALL have port s, ds_if.slv (DTYPE, FC), upstream side.
REQ-007 SHALL have port m, ds_if.mst (DTYPE, FC), downstream side.
REQ-008 SHALL have port cnt, output, $clog2(2*STAGES+1) bits, number of words currently held.

Function
REQ-009 SHALL, for FC_BI, build each stage as a 2-entry skid buffer with states EMPTY, ONE, FULL.
- EMPTY->ONE on accept.
- ONE->FULL on accept without drain.
- FULL->ONE on drain.
- ONE->EMPTY on drain without accept.
REQ-010 SHALL, per stage, drive upstream rdy from a flop (not combinationally from downstream rdy): rdy=1 in EMPTY/ONE, 0 in FULL.
REQ-011 SHALL accept and drain in the same cycle in state ONE, staying in ONE (100% throughput, one word/cycle sustained).
REQ-012 SHALL give FC_BI latency of STAGES cycles from s.xfer to earliest m.vld, with downstream always ready.
REQ-013 SHALL deliver words in order, with no loss or duplication.
REQ-014 SHALL hold m.data and m.vld stable while m.vld=1 and m.rdy=0.
REQ-015 SHALL, for FC_UNI, tie s.rdy=1, pipe vld and data through STAGES plain flops, and ignore m.rdy; latency STAGES.
REQ-016 SHALL, for FC_NO, tie s.rdy=1 and pipe only data through STAGES flops; vld is not stored.
REQ-017 SHALL have cnt = accepted minus delivered words.
- FC_BI: max 2*STAGES.
- FC_UNI: count of valid flops.
- FC_NO: constant STAGES after STAGES cycles from reset, 0 before.
REQ-018 SHALL, with m.rdy held 0 in FC_BI, fill to cnt=2*STAGES; s.rdy then drops to 0 within STAGES cycles of the last stage filling.
REQ-019 SHALL allow data to take any value while vld=0; the data register updates only on accept, which saves power.

Reset
REQ-020 SHALL, on rst_n=0, asynchronously clear every stage to EMPTY, all vld flops to 0, and cnt to 0.
REQ-021 SHALL drive s.rdy=1 (FC_BI) from the first edge after rst_n deasserts.
REQ-022 SHALL NOT reset data registers.
REQ-023 SHALL discard in-flight words on reset mid-transfer, with no partial output afterwards.

Structure
REQ-024 SHALL take t_fc from ds_pkg; ds_pkg also gains the constant DS_MAX_STAGES=16 and a count-width function used for cnt.
REQ-025 SHALL implement one FC_BI stage as sub-module ds_skid (clk, rst_n, ds_if.slv, ds_if.mst), instantiated STAGES times via generate.
REQ-026 SHALL select the FC_UNI/FC_NO paths by generate case on FC, with no ds_skid instantiated in those modes.

Verification
REQ-027 SHALL test FC_BI, STAGES=2, m.rdy=1, 8 back-to-back words 0x00..0x07 -> m.vld first at cycle 2, outputs 0x00..0x07 on consecutive cycles, cnt peaks at 2.
REQ-028 SHALL test FC_BI, STAGES=3, m.rdy=0, push 0xA0.. -> s.rdy falls after 6 accepts, cnt=6; raise m.rdy -> 0xA0..0xA5 in order, cnt returns to 0.
REQ-029 SHALL test FC_BI, STAGES=1, random vld/rdy (50%) for 1000 words -> scoreboard order match, m.data stable whenever stalled.
REQ-030 SHALL test FC_UNI, STAGES=4, vld pulses on words 0x11 and 0x22 two cycles apart -> same pattern at output 4 cycles later regardless of m.rdy.
REQ-031 SHALL test FC_BI, STAGES=2, assert rst_n=0 with cnt=3 -> cnt=0 and m.vld=0 immediately (asynchronous), s.rdy=1 first cycle after release.
REQ-032 SHALL test FC_NO, STAGES=2, data ramp 0..9 -> m.data equals input delayed 2 cycles, s.rdy constant 1.
